// File: rtl/axi_node_pkg.sv
// Shared AXI node definitions: response codes, error-responder
// state encoding and the error read-data fill pattern.
package axi_node_pkg;

  localparam logic [1:0]  RESP_DECERR      = 2'b11;
  localparam logic [31:0] ERR_DATA_PATTERN = 32'hBADACCE5;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    RESP
  } err_state_e;

endpackage

// File: rtl/axi_outstanding_counter.sv
// Saturating outstanding-transaction counter with two increment
// and two decrement strobes; shared by the read and write sides.
module axi_outstanding_counter #(
  parameter int CNT_WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic incr_a_i,
  input  logic incr_b_i,
  input  logic decr_a_i,
  input  logic decr_b_i,
  output logic outstanding_o,
  output logic full_o
);

  localparam int W = CNT_WIDTH + 2;
  localparam logic [W-1:0] MAX = {2'b00, {CNT_WIDTH{1'b1}}};

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0]         up, dn, net;

  // Net change clamped to [0, MAX]; both ends drop the excess.
  always_comb begin
    up  = W'(cnt_q) + W'(incr_a_i) + W'(incr_b_i);
    dn  = W'(decr_a_i) + W'(decr_b_i);
    net = (up < dn) ? '0 : (up - dn);
    if (net > MAX) begin
      cnt_d = '1;
    end else begin
      cnt_d = net[CNT_WIDTH-1:0];
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign outstanding_o = (cnt_q != '0);
  assign full_o        = (cnt_q == '1);

endmodule

// File: rtl/axi_read_error_responder.sv
// Read-side DECERR responder for unmapped AR requests.
// Define AXI_RD_ERR_DATA_PATTERN_EN to fill rdata with 0xBADACCE5.
module axi_read_error_responder
  import axi_node_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 6,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_ardata_info_i,
  input  logic [ID_WIDTH-1:0]   arid_i,
  input  logic [7:0]            arlen_i,
  input  logic [USER_WIDTH-1:0] aruser_i,
  output logic                  error_gnt_o,
  input  logic                  incr_req_i,
  input  logic                  rlast_done_i,
  output logic                  outstanding_trans_o,
  output logic                  full_counter_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [ID_WIDTH-1:0]   rid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rlast_o,
  output logic [USER_WIDTH-1:0] ruser_o
);

  err_state_e            state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            len_q, len_d;
  logic [USER_WIDTH-1:0] user_q, user_d;
  logic [7:0]            beat_q, beat_d;

  logic in_resp;
  logic last_beat;
  logic gnt;
  logic last_hs;

  // Next state, capture and beat countdown.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    user_d  = user_q;
    beat_d  = beat_q;
    gnt     = 1'b0;
    last_hs = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sample_ardata_info_i) begin
          id_d    = arid_i;
          len_d   = arlen_i;
          user_d  = aruser_i;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!outstanding_trans_o) begin
          gnt     = 1'b1;
          beat_d  = len_q;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rready_i) begin
          if (beat_q == 8'd0) begin
            last_hs = 1'b1;
            state_d = IDLE;
          end else begin
            beat_d = beat_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-field registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      len_q   <= '0;
      user_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      user_q  <= user_d;
      beat_q  <= beat_d;
    end
  end

  axi_outstanding_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk           (clk),
    .rst_n         (rst_n),
    .incr_a_i      (incr_req_i),
    .incr_b_i      (gnt),
    .decr_a_i      (rlast_done_i),
    .decr_b_i      (last_hs),
    .outstanding_o (outstanding_trans_o),
    .full_o        (full_counter_o)
  );

  assign in_resp   = (state_q == RESP);
  assign last_beat = (beat_q == 8'd0);

  assign error_gnt_o = gnt;
  assign rvalid_o    = in_resp;
  assign rlast_o     = in_resp & last_beat;
  assign rresp_o     = in_resp ? RESP_DECERR : 2'b00;
  assign rid_o       = in_resp ? id_q : '0;
  assign ruser_o     = in_resp ? user_q : '0;

`ifdef AXI_RD_ERR_DATA_PATTERN_EN
  logic [DATA_WIDTH-1:0] pat;

  // Pattern repeated across the bus, truncated at the top.
  always_comb begin
    pat = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      pat[i] = ERR_DATA_PATTERN[i[4:0]];
    end
  end

  assign rdata_o = in_resp ? pat : '0;
`else
  assign rdata_o = '0;
`endif

endmodule

// File: tb/tb_axi_read_error_responder.sv
// Directed bench for axi_read_error_responder (CNT_WIDTH=2).
// Builds with or without AXI_RD_ERR_DATA_PATTERN_EN.
module tb_axi_read_error_responder;

  localparam int IDW = 4;
  localparam int UW  = 6;
  localparam int DW  = 64;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          smp;
  logic [IDW-1:0] arid;
  logic [7:0]    arlen;
  logic [UW-1:0] aruser;
  logic          gnt;
  logic          incr;
  logic          rld;
  logic          outst;
  logic          full;
  logic          rvalid;
  logic          rready;
  logic [IDW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic [UW-1:0] ruser;

  int total = 0;
  int bad = 0;

  axi_read_error_responder #(
    .ID_WIDTH   (IDW),
    .USER_WIDTH (UW),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .sample_ardata_info_i (smp),
    .arid_i               (arid),
    .arlen_i              (arlen),
    .aruser_i             (aruser),
    .error_gnt_o          (gnt),
    .incr_req_i           (incr),
    .rlast_done_i         (rld),
    .outstanding_trans_o  (outst),
    .full_counter_o       (full),
    .rvalid_o             (rvalid),
    .rready_i             (rready),
    .rid_o                (rid),
    .rdata_o              (rdata),
    .rresp_o              (rresp),
    .rlast_o              (rlast),
    .ruser_o              (ruser)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           smp;
    logic [IDW-1:0] arid;
    logic [7:0]     arlen;
    logic [UW-1:0]  aruser;
    logic           incr;
    logic           rld;
    logic           rready;
    logic           e_gnt;
    logic           e_rv;
    logic           e_last;
    logic [IDW-1:0] e_rid;
    logic [UW-1:0]  e_user;
    logic           e_outst;
    logic           e_full;
  } vec_t;

  vec_t vt[$];

  function automatic logic [DW-1:0] exp_data(input logic rv);
`ifdef AXI_RD_ERR_DATA_PATTERN_EN
    logic [DW-1:0] p;
    p = 64'hBADACCE5BADACCE5;
    return rv ? p : '0;
`else
    return rv ? '0 : '0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    smp = 0; arid = '0; arlen = '0; aruser = '0;
    incr = 0; rld = 0; rready = 0;
  endtask

  task automatic add(input logic s, input int id, input int ln,
                     input int us, input logic in, input logic rd,
                     input logic rr, input logic g, input logic v,
                     input logic l, input int eid, input int eus,
                     input logic o, input logic f);
    vec_t x;
    x.smp = s; x.arid = IDW'(id); x.arlen = 8'(ln);
    x.aruser = UW'(us); x.incr = in; x.rld = rd; x.rready = rr;
    x.e_gnt = g; x.e_rv = v; x.e_last = l; x.e_rid = IDW'(eid);
    x.e_user = UW'(eus); x.e_outst = o; x.e_full = f;
    vt.push_back(x);
  endtask

  task automatic wait_gnt(input string nm);
    bit seen;
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      smp = 0;
      #1;
      if (gnt) seen = 1;
    end
    chk(nm, 64'(seen), 64'd1);
  endtask

  initial begin
    logic [IDW-1:0] s_id;
    logic [DW-1:0]  s_data;
    idle_in();

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rvalid", 64'(rvalid), 0);
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_outst", 64'(outst), 0);
    chk("rst_full", 64'(full), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rid", 64'(rid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // s id ln us in rd rr | g v l rid us o f
    // 4-beat burst, sample during RESP ignored.
    add(1,3,3,5, 0,0,1, 0,0,0,0,0, 0,0);
    add(0,0,0,0, 0,0,1, 1,0,0,0,0, 0,0);
    add(0,0,0,0, 0,0,1, 0,1,0,3,5, 1,0);
    add(1,7,0,1, 0,0,1, 0,1,0,3,5, 1,0);
    add(0,0,0,0, 0,0,1, 0,1,0,3,5, 1,0);
    add(0,0,0,0, 0,0,1, 0,1,1,3,5, 1,0);
    add(0,0,0,0, 0,0,1, 0,0,0,0,0, 0,0);
    // Drain two routed transactions before the grant.
    add(0,0,0,0, 1,0,0, 0,0,0,0,0, 0,0);
    add(0,0,0,0, 1,0,0, 0,0,0,0,0, 1,0);
    add(1,1,1,2, 0,0,0, 0,0,0,0,0, 1,0);
    add(0,0,0,0, 0,0,0, 0,0,0,0,0, 1,0);
    add(0,0,0,0, 0,1,0, 0,0,0,0,0, 1,0);
    add(0,0,0,0, 0,1,0, 0,0,0,0,0, 1,0);
    add(0,0,0,0, 0,0,0, 1,0,0,0,0, 0,0);
    add(0,0,0,0, 0,0,0, 0,1,0,1,2, 1,0);
    add(0,0,0,0, 0,0,1, 0,1,0,1,2, 1,0);
    add(0,0,0,0, 0,0,1, 0,1,1,1,2, 1,0);
    add(0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0);
    // Saturation at 3 and at 0.
    add(0,0,0,0, 1,0,0, 0,0,0,0,0, 0,0);
    add(0,0,0,0, 1,0,0, 0,0,0,0,0, 1,0);
    add(0,0,0,0, 1,0,0, 0,0,0,0,0, 1,0);
    add(0,0,0,0, 1,0,0, 0,0,0,0,0, 1,1);
    add(0,0,0,0, 1,1,0, 0,0,0,0,0, 1,1);
    add(0,0,0,0, 0,1,0, 0,0,0,0,0, 1,1);
    add(0,0,0,0, 0,1,0, 0,0,0,0,0, 1,0);
    add(0,0,0,0, 0,1,0, 0,0,0,0,0, 1,0);
    add(0,0,0,0, 0,1,0, 0,0,0,0,0, 0,0);
    add(0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0);

    foreach (vt[i]) begin
      string t;
      @(negedge clk);
      smp = vt[i].smp; arid = vt[i].arid; arlen = vt[i].arlen;
      aruser = vt[i].aruser; incr = vt[i].incr; rld = vt[i].rld;
      rready = vt[i].rready;
      #1;
      t = $sformatf("v%0d", i);
      chk({t, "_gnt"}, 64'(gnt), 64'(vt[i].e_gnt));
      chk({t, "_rv"}, 64'(rvalid), 64'(vt[i].e_rv));
      chk({t, "_last"}, 64'(rlast), 64'(vt[i].e_last));
      chk({t, "_rid"}, 64'(rid), 64'(vt[i].e_rid));
      chk({t, "_user"}, 64'(ruser), 64'(vt[i].e_user));
      chk({t, "_resp"}, 64'(rresp), vt[i].e_rv ? 64'd3 : 64'd0);
      chk({t, "_data"}, rdata, exp_data(vt[i].e_rv));
      chk({t, "_outst"}, 64'(outst), 64'(vt[i].e_outst));
      chk({t, "_full"}, 64'(full), 64'(vt[i].e_full));
    end

    // Single beat held under backpressure.
    @(negedge clk);
    idle_in();
    smp = 1; arid = 4'd9; arlen = 8'd0; aruser = 6'd6;
    wait_gnt("hold_gnt");
    @(negedge clk);
    #1;
    s_id = rid;
    s_data = rdata;
    chk("hold_id0", 64'(s_id), 64'd9);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      chk("hold_rv", 64'(rvalid), 1);
      chk("hold_last", 64'(rlast), 1);
      chk("hold_rid", 64'(rid), 64'(s_id));
      chk("hold_data", rdata, s_data);
      chk("hold_resp", 64'(rresp), 3);
      chk("hold_user", 64'(ruser), 6);
    end
    @(negedge clk);
    rready = 1;
    @(negedge clk);
    rready = 0;
    #1;
    chk("hold_done_rv", 64'(rvalid), 0);
    chk("hold_done_outst", 64'(outst), 0);

    // Reset during beat 2 of an 8-beat burst.
    @(negedge clk);
    smp = 1; arid = 4'd5; arlen = 8'd7; aruser = 6'd1;
    rready = 1;
    wait_gnt("rst_mid_gnt");
    @(negedge clk);
    #1;
    chk("rst_mid_b1", 64'(rvalid), 1);
    @(negedge clk);
    #1;
    chk("rst_mid_b2", 64'(rvalid), 1);
    chk("rst_mid_b2last", 64'(rlast), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rv", 64'(rvalid), 0);
    chk("rst_mid_outst", 64'(outst), 0);
    chk("rst_mid_rid", 64'(rid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("post_rst_rv", 64'(rvalid), 0);
      chk("post_rst_gnt", 64'(gnt), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_read_error_responder.md
AXI_READ_ERROR_RESPONDER -- requirements
Module: axi_read_error_responder

Interface
REQ-001 SHALL have parameters: ID_WIDTH, default 4, AR/R ID width; USER_WIDTH, default 6, user width; DATA_WIDTH, default 64, R data width; CNT_WIDTH, default 4, outstanding counter width.
REQ-002 SHALL have ports: clk  in  1  single clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: sample_ardata_info_i  in  1  decoder accepted an unmapped AR this cycle; arid_i  in  ID_WIDTH; arlen_i  in  8; aruser_i  in  USER_WIDTH.
REQ-004 SHALL have ports: error_gnt_o  out  1  error burst granted to decoder; incr_req_i  in  1  routed AR accepted; rlast_done_i  in  1  routed R last-beat handshake completed.
REQ-005 SHALL have ports: outstanding_trans_o  out  1  counter non-zero; full_counter_o  out  1  counter at max.
REQ-006 SHALL have ports: rvalid_o  out  1; rready_i  in  1; rid_o  out  ID_WIDTH; rdata_o  out  DATA_WIDTH; rresp_o  out  2; rlast_o  out  1; ruser_o  out  USER_WIDTH.

Function
REQ-007 SHALL implement FSM states IDLE, DRAIN, RESP.
REQ-008 IDLE: on sample_ardata_info_i=1, SHALL capture arid_i/arlen_i/aruser_i and enter DRAIN next cycle; otherwise stay.
REQ-009 DRAIN: when outstanding count==0, SHALL assert error_gnt_o for exactly one cycle, load beat counter with captured arlen, and enter RESP; else stay, error_gnt_o=0.
REQ-010 RESP: SHALL drive rvalid_o=1, rresp_o=2'b11 (DECERR), rid_o/ruser_o = captured values, rlast_o=1 only when beat counter==0.
REQ-011 SHALL decrement the beat counter on rvalid_o&rready_i; on handshake with rlast_o=1, return to IDLE next cycle.
REQ-012 SHALL emit exactly arlen+1 beats per error burst; arlen=0 gives one beat with rlast_o=1.
REQ-013 rvalid_o SHALL stay asserted with stable rid/rdata/rresp/rlast/ruser until handshake.
REQ-014 sample_ardata_info_i while not IDLE SHALL be ignored (decoder stalls in its ERROR state).
REQ-015 Outstanding counter: +1 on incr_req_i, +1 on error_gnt_o, -1 on rlast_done_i, -1 on error last-beat handshake; net change per cycle = increments minus decrements.
REQ-016 Counter SHALL saturate at 2^CNT_WIDTH-1 (excess increments dropped) and at 0 (decrement dropped).
REQ-017 outstanding_trans_o=(count!=0), full_counter_o=(count==max), both combinational from the registered count.
REQ-018 error_gnt_o SHALL be combinational from state and count; no other output may depend combinationally on rready_i.

Reset
REQ-019 On rst_n=0, at any time, SHALL go to IDLE, count=0, beat counter=0, captured fields=0; all outputs 0.
REQ-020 Reset mid-burst SHALL abort the burst; no further beats after deassertion.

Configuration
REQ-021 With AXI_RD_ERR_DATA_PATTERN_EN defined, rdata_o SHALL be 32'hBADACCE5 replicated to DATA_WIDTH (truncated if not a multiple of 32) during RESP.
REQ-022 Without it, rdata_o SHALL be all zeros at all times.

Structure
REQ-023 Shared package axi_node_pkg SHALL hold: RESP_DECERR constant (2'b11), error-responder state enum typedef, ERR_DATA_PATTERN constant.
REQ-024 Outstanding counter SHALL be sub-module axi_outstanding_counter (incr/decr inputs, saturation, outstanding/full outputs), reusable by the write side.

Verification
REQ-025 Idle, count=0; sample with arid=3, arlen=3 -> error_gnt_o pulse 1 cycle after sample, 4 DECERR beats rid=3, rlast on 4th only.
REQ-026 Two incr_req_i pulses, then error sample -> stays DRAIN, error_gnt_o=0 until two rlast_done_i, grant in cycle count reaches 0.
REQ-027 arlen=0, rready_i low 5 cycles -> single beat held stable 5 cycles, rlast_o=1, IDLE after handshake.
REQ-028 CNT_WIDTH=2: 4 incr_req_i -> count=3, full_counter_o=1; incr_req_i and rlast_done_i same cycle -> count unchanged.
REQ-029 rst_n low during beat 2 of arlen=7 burst -> rvalid_o=0 immediately, IDLE, outstanding_trans_o=0.
REQ-030 Build with and without AXI_RD_ERR_DATA_PATTERN_EN, DATA_WIDTH=64 -> rdata_o 64'hBADACCE5BADACCE5 vs 0.
